// File: rtl/preadder_thread_scheduler.sv
// -----------------------------------------------------------------------------
// preadder_thread_scheduler
//
// Sequencer for an N-thread interleaved pre-adder. A free-running slot counter
// hands one input slot per thread every N_THREADS cycles. Each thread accepts a
// job (op + beat count), strobes its operand source in its own slot, and the
// job's tag travels down a delay line so that the pre-adder mode lines up with
// the matching result and the result markers line up with the Z0/Z1 register.
//
// Ports
//   clk        : clock
//   rstn       : synchronous reset, active-high (1 = reset)
//   req_valid  : per-thread job request
//   req_ready  : per-thread job accept (thread idle)
//   req_op     : per-thread op, 2 bits each: 00 PASS, 01 ADJ_ADD, 10 ADD_SUB
//   req_len    : per-thread beat count, LEN_W bits each (0 is illegal)
//   slot_tid   : thread owning the current input slot
//   beat_rd    : one-hot, operand source must drive X/Y this cycle
//   mode       : pre-adder mode, aligned to the result leaving the pre-adder
//   res_valid  : Z0/Z1 holds a valid result
//   res_tid    : thread of the result
//   res_first  : first valid result of the job
//   res_last   : last result of the job
//   done       : per-thread one-cycle pulse when the job's last result is out
//
// N_THREADS must be >= 2 and PRE_LAT must be >= 2.
// -----------------------------------------------------------------------------
module preadder_thread_scheduler #(
  parameter int N_THREADS = 4,
  parameter int PRE_LAT   = N_THREADS + 1,
  parameter int LEN_W     = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_THREADS-1:0]           req_valid,
  output logic [N_THREADS-1:0]           req_ready,
  input  logic [2*N_THREADS-1:0]         req_op,
  input  logic [LEN_W*N_THREADS-1:0]     req_len,
  output logic [$clog2(N_THREADS)-1:0]   slot_tid,
  output logic [N_THREADS-1:0]           beat_rd,
  output logic [1:0]                     mode,
  output logic                           res_valid,
  output logic [$clog2(N_THREADS)-1:0]   res_tid,
  output logic                           res_first,
  output logic                           res_last,
  output logic [N_THREADS-1:0]           done
);

  localparam int TID_W = $clog2(N_THREADS);
  // Tag delay line depth: the final pre-adder stage consumes the tail (mode),
  // and the result registers add the last cycle of PRE_LAT.
  localparam int DEPTH = PRE_LAT - 1;
  localparam logic [TID_W-1:0] SLOT_MAX = TID_W'(N_THREADS - 1);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADJ  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic             issued;
    logic [TID_W-1:0] tid;
    logic [1:0]       op;
    logic             first;   // beat index 0
    logic             second;  // beat index 1 (first result of ADJ_ADD)
    logic             last;
  } tag_t;

  // ---------------------------------------------------------------------------
  // Module-level signals
  // ---------------------------------------------------------------------------
  logic [TID_W-1:0]     r_slot;
  logic [N_THREADS-1:0] w_issue;
  logic [N_THREADS-1:0] w_idle;
  logic [N_THREADS-1:0] w_ill;
  logic [1:0]           w_thr_op     [N_THREADS];
  logic                 w_thr_first  [N_THREADS];
  logic                 w_thr_second [N_THREADS];
  logic                 w_thr_last   [N_THREADS];

  tag_t                 w_tag_in;
  tag_t                 r_tag [DEPTH];
  tag_t                 w_tail;
  logic                 w_tail_adj;
  logic                 w_res_valid_next;
  logic [N_THREADS-1:0] w_done_next;

  logic                 r_res_valid;
  logic [TID_W-1:0]     r_res_tid;
  logic                 r_res_first;
  logic                 r_res_last;
  logic [N_THREADS-1:0] r_done;

  // ---------------------------------------------------------------------------
  // Free-running slot counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_slot <= '0;
    end else if (r_slot == SLOT_MAX) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + TID_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-thread job FSMs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_thr
    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_op;
    logic [1:0]       w_op_next;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_next;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_idx_next;
    logic [1:0]       w_req_op;
    logic [LEN_W-1:0] w_req_len;
    logic             w_own;
    logic             w_issue_t;
    logic             w_ill_t;

    assign w_req_op  = req_op[2*gi +: 2];
    assign w_req_len = req_len[LEN_W*gi +: LEN_W];
    assign w_own     = (r_slot == TID_W'(gi));

    always_ff @(posedge clk) begin
      if (rstn) begin
        r_state <= S_IDLE;
        r_op    <= OP_PASS;
        r_rem   <= '0;
        r_idx   <= '0;
      end else begin
        r_state <= w_state_next;
        r_op    <= w_op_next;
        r_rem   <= w_rem_next;
        r_idx   <= w_idx_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_op_next    = r_op;
      w_rem_next   = r_rem;
      w_idx_next   = r_idx;
      w_issue_t    = 1'b0;
      w_ill_t      = 1'b0;
      if (!rstn) begin
        case (r_state)
          S_IDLE: begin
            if (req_valid[gi]) begin
              if (w_req_op == OP_RSVD || w_req_len == '0) begin
                // Swallowed job: stays idle, completion reported next cycle.
                w_ill_t = 1'b1;
              end else begin
                w_op_next    = w_req_op;
                w_rem_next   = w_req_len;
                w_idx_next   = '0;
                w_state_next = S_WAIT;
              end
            end
          end
          S_WAIT, S_RUN: begin
            // The first beat may go out in WAIT if the own slot arrives
            // immediately; the final beat frees the thread at the same edge.
            if (w_own) begin
              w_issue_t    = 1'b1;
              w_rem_next   = r_rem - LEN_W'(1);
              w_idx_next   = r_idx + LEN_W'(1);
              w_state_next = (r_rem == LEN_W'(1)) ? S_IDLE : S_RUN;
            end
          end
          default: w_state_next = S_IDLE;
        endcase
      end
    end

    assign w_idle[gi]       = (r_state == S_IDLE);
    assign w_issue[gi]      = w_issue_t;
    assign w_ill[gi]        = w_ill_t;
    assign w_thr_op[gi]     = r_op;
    assign w_thr_first[gi]  = (r_idx == '0);
    assign w_thr_second[gi] = (r_idx == LEN_W'(1));
    assign w_thr_last[gi]   = (r_rem == LEN_W'(1));

    // Slots are exclusive, so at most one thread's tag reaches the tail.
    assign w_done_next[gi] = (w_tail.issued && w_tail.last &&
                              (w_tail.tid == TID_W'(gi))) || w_ill[gi];
  end

  assign req_ready = w_idle & {N_THREADS{~rstn}};
  assign beat_rd   = w_issue;
  assign slot_tid  = r_slot;

  // ---------------------------------------------------------------------------
  // Tag delay line
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tag_in = '0;
    if (|w_issue) begin
      w_tag_in.issued = 1'b1;
      w_tag_in.tid    = r_slot;
      w_tag_in.op     = w_thr_op[r_slot];
      w_tag_in.first  = w_thr_first[r_slot];
      w_tag_in.second = w_thr_second[r_slot];
      w_tag_in.last   = w_thr_last[r_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_tail     = r_tag[DEPTH-1];
  assign w_tail_adj = (w_tail.op == OP_ADJ);
  assign mode       = w_tail.issued ? w_tail.op : OP_PASS;

  // ADJ_ADD beat 0 has no earlier partner, so it produces no result.
  assign w_res_valid_next = w_tail.issued && !(w_tail_adj && w_tail.first);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_res_valid <= 1'b0;
      r_res_tid   <= '0;
      r_res_first <= 1'b0;
      r_res_last  <= 1'b0;
      r_done      <= '0;
    end else begin
      r_res_valid <= w_res_valid_next;
      r_res_tid   <= w_tail.tid;
      r_res_first <= w_res_valid_next &&
                     (w_tail_adj ? w_tail.second : w_tail.first);
      r_res_last  <= w_res_valid_next && w_tail.last;
      r_done      <= w_done_next;
    end
  end

  assign res_valid = r_res_valid;
  assign res_tid   = r_res_tid;
  assign res_first = r_res_first;
  assign res_last  = r_res_last;
  assign done      = r_done;

endmodule

// File: tb/tb_preadder_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_preadder_thread_scheduler
//
// Directed bench for preadder_thread_scheduler (N_THREADS=4, PRE_LAT=5,
// LEN_W=4). Each scenario fills per-cycle expectation tables by hand and then
// walks the window cycle by cycle, comparing every output at the falling edge.
// -----------------------------------------------------------------------------
module tb_preadder_thread_scheduler;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int NE = 40;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [LW*N-1:0] req_len;
  logic [1:0]      slot_tid;
  logic [N-1:0]    beat_rd;
  logic [1:0]      mode;
  logic            res_valid;
  logic [1:0]      res_tid;
  logic            res_first;
  logic            res_last;
  logic [N-1:0]    done;

  preadder_thread_scheduler #(
    .N_THREADS (N),
    .PRE_LAT   (N + 1),
    .LEN_W     (LW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_len   (req_len),
    .slot_tid  (slot_tid),
    .beat_rd   (beat_rd),
    .mode      (mode),
    .res_valid (res_valid),
    .res_tid   (res_tid),
    .res_first (res_first),
    .res_last  (res_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tb_slot = 0;

  // Expectation tables, indexed by cycle offset inside a window.
  logic [N-1:0] e_beat  [NE];
  logic [N-1:0] e_rdy   [NE];
  logic [N-1:0] e_done  [NE];
  logic [1:0]   e_mode  [NE];
  logic         e_rv    [NE];
  logic [1:0]   e_tid   [NE];
  logic         e_first [NE];
  logic         e_last  [NE];

  // Optional second request issued mid-window.
  int          re_off = -1;
  int          re_t   = 0;
  logic [1:0]  re_op  = 2'b00;
  logic [3:0]  re_len = 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tb_slot   = (tb_slot + 1) % N;
    req_valid = '0;
  endtask

  task automatic set_req(input int t, input logic [1:0] op, input logic [3:0] len);
    req_valid[t]        = 1'b1;
    req_op[2*t +: 2]    = op;
    req_len[LW*t +: LW] = len;
  endtask

  task automatic idle_to(input int s);
    for (int k = 0; k < N && tb_slot != s; k++) step();
  endtask

  task automatic clr_exp();
    for (int o = 0; o < NE; o++) begin
      e_beat[o]  = '0;
      e_rdy[o]   = '1;
      e_done[o]  = '0;
      e_mode[o]  = 2'b00;
      e_rv[o]    = 1'b0;
      e_tid[o]   = 2'd0;
      e_first[o] = 1'b0;
      e_last[o]  = 1'b0;
    end
  endtask

  task automatic exp_res(input int o, input int t, input logic f, input logic l);
    e_rv[o]    = 1'b1;
    e_tid[o]   = 2'(t);
    e_first[o] = f;
    e_last[o]  = l;
  endtask

  task automatic exp_busy(input int t, input int a, input int b);
    for (int o = a; o <= b; o++) e_rdy[o][t] = 1'b0;
  endtask

  task automatic run_window(input string name, input int n);
    for (int o = 0; o < n; o++) begin
      if (o == re_off) set_req(re_t, re_op, re_len);
      @(negedge clk);
      chk($sformatf("%s.slot_tid@%0d", name, o), 32'(slot_tid), 32'(tb_slot));
      chk($sformatf("%s.beat_rd@%0d", name, o), 32'(beat_rd), 32'(e_beat[o]));
      chk($sformatf("%s.req_ready@%0d", name, o), 32'(req_ready), 32'(e_rdy[o]));
      chk($sformatf("%s.mode@%0d", name, o), 32'(mode), 32'(e_mode[o]));
      chk($sformatf("%s.res_valid@%0d", name, o), 32'(res_valid), 32'(e_rv[o]));
      if (e_rv[o]) chk($sformatf("%s.res_tid@%0d", name, o), 32'(res_tid), 32'(e_tid[o]));
      chk($sformatf("%s.res_first@%0d", name, o), 32'(res_first), 32'(e_first[o]));
      chk($sformatf("%s.res_last@%0d", name, o), 32'(res_last), 32'(e_last[o]));
      chk($sformatf("%s.done@%0d", name, o), 32'(done), 32'(e_done[o]));
      $display("step %s cyc=%0d slot=%0d beat_rd=%b mode=%b rv=%b tid=%0d f=%b l=%b done=%b",
               name, o, slot_tid, beat_rd, mode, res_valid, res_tid, res_first, res_last, done);
      step();
    end
    re_off = -1;
  endtask

  task automatic chk_reset_state(input string name);
    @(negedge clk);
    chk({name, ".slot_tid"},  32'(slot_tid),  32'd0);
    chk({name, ".req_ready"}, 32'(req_ready), 32'd0);
    chk({name, ".beat_rd"},   32'(beat_rd),   32'd0);
    chk({name, ".mode"},      32'(mode),      32'd0);
    chk({name, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({name, ".res_first"}, 32'(res_first), 32'd0);
    chk({name, ".res_last"},  32'(res_last),  32'd0);
    chk({name, ".done"},      32'(done),      32'd0);
  endtask

  initial begin
    rstn      = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_len   = '0;

    // Reset held for three edges; outputs must be quiet while it is held.
    step();
    step();
    chk_reset_state("reset");
    step();
    rstn    = 1'b0;
    tb_slot = 0;

    // Idle: slot counter runs, nothing else moves.
    clr_exp();
    run_window("idle", 12);

    // Thread 2 PASS len 3 accepted at slot 0.
    idle_to(0);
    clr_exp();
    set_req(2, 2'b00, 4'd3);
    e_beat[2][2] = 1'b1; e_beat[6][2] = 1'b1; e_beat[10][2] = 1'b1;
    exp_res(7, 2, 1'b1, 1'b0);
    exp_res(11, 2, 1'b0, 1'b0);
    exp_res(15, 2, 1'b0, 1'b1);
    e_done[15][2] = 1'b1;
    exp_busy(2, 1, 10);
    run_window("pass_t2", 17);

    // Thread 1 ADJ_ADD len 4: beat 0 yields no result.
    idle_to(0);
    clr_exp();
    set_req(1, 2'b01, 4'd4);
    e_beat[1][1] = 1'b1; e_beat[5][1] = 1'b1; e_beat[9][1] = 1'b1; e_beat[13][1] = 1'b1;
    e_mode[5] = 2'b01; e_mode[9] = 2'b01; e_mode[13] = 2'b01; e_mode[17] = 2'b01;
    exp_res(10, 1, 1'b1, 1'b0);
    exp_res(14, 1, 1'b0, 1'b0);
    exp_res(18, 1, 1'b0, 1'b1);
    e_done[18][1] = 1'b1;
    exp_busy(1, 1, 13);
    run_window("adj_t1", 20);

    // All threads ADD_SUB len 2 at once.
    idle_to(0);
    clr_exp();
    for (int t = 0; t < N; t++) set_req(t, 2'b10, 4'd2);
    for (int k = 1; k <= 8; k++) begin
      e_beat[k][k % N] = 1'b1;
      e_mode[k + 4]    = 2'b10;
      exp_res(k + 5, k % N, k <= 4, k > 4);
      if (k > 4) e_done[k + 5][k % N] = 1'b1;
    end
    exp_busy(0, 1, 8);
    for (int t = 1; t < N; t++) exp_busy(t, 1, t + 4);
    run_window("all4", 15);

    // Thread 0 back-to-back: PASS len 1, then ADD_SUB len 2 the cycle after.
    idle_to(3);
    clr_exp();
    set_req(0, 2'b00, 4'd1);
    re_off = 2; re_t = 0; re_op = 2'b10; re_len = 4'd2;
    e_beat[1][0] = 1'b1; e_beat[5][0] = 1'b1; e_beat[9][0] = 1'b1;
    e_mode[9] = 2'b10; e_mode[13] = 2'b10;
    exp_res(6, 0, 1'b1, 1'b1);
    e_done[6][0] = 1'b1;
    exp_res(10, 0, 1'b1, 1'b0);
    exp_res(14, 0, 1'b0, 1'b1);
    e_done[14][0] = 1'b1;
    exp_busy(0, 1, 1);
    exp_busy(0, 3, 9);
    run_window("b2b_t0", 16);

    // 1-beat ADJ_ADD on thread 3 plus zero-length job on thread 2.
    idle_to(0);
    clr_exp();
    set_req(3, 2'b01, 4'd1);
    set_req(2, 2'b00, 4'd0);
    e_beat[3][3] = 1'b1;
    e_mode[7]    = 2'b01;
    e_done[1][2] = 1'b1;
    e_done[8][3] = 1'b1;
    exp_busy(3, 1, 3);
    run_window("edge", 10);

    // Reset while thread 3 has 2 beats outstanding.
    idle_to(0);
    clr_exp();
    set_req(3, 2'b10, 4'd3);
    e_beat[3][3] = 1'b1;
    exp_busy(3, 1, 4);
    run_window("pre_rst", 5);
    rstn = 1'b1;
    step();
    chk_reset_state("mid_rst");
    step();
    rstn    = 1'b0;
    tb_slot = 0;

    // Fresh job after reset; no stale result or done from the discarded job.
    clr_exp();
    set_req(3, 2'b00, 4'd2);
    e_beat[3][3] = 1'b1; e_beat[7][3] = 1'b1;
    exp_res(8, 3, 1'b1, 1'b0);
    exp_res(12, 3, 1'b0, 1'b1);
    e_done[12][3] = 1'b1;
    exp_busy(3, 1, 7);
    run_window("post_rst", 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
